// File: rtl/fan_pwm_multi_ctrl_if.sv
// Control/driver-side bus of the multi-channel fan PWM block.
// master = duty/temperature control side, slave = PWM generator.
interface fan_pwm_multi_ctrl_if #(
    parameter int unsigned COUNTER_BITWIDTH = 8,
    parameter int unsigned NUM_CH           = 2
);
    logic                                 clk_en_i;
    logic [NUM_CH*COUNTER_BITWIDTH-1:0]   duty_i;
    logic [COUNTER_BITWIDTH-1:0]          minDuty_i;
    logic [COUNTER_BITWIDTH:0]            period_i;
    logic [NUM_CH-1:0]                    enable_i;
    logic                                 kickEn_i;
    logic [NUM_CH-1:0]                    pwm_o;
    logic [NUM_CH-1:0]                    kickActive_o;
    logic                                 periodStrobe_o;

    modport master (
        output clk_en_i, duty_i, minDuty_i, period_i, enable_i, kickEn_i,
        input  pwm_o, kickActive_o, periodStrobe_o
    );

    modport slave (
        input  clk_en_i, duty_i, minDuty_i, period_i, enable_i, kickEn_i,
        output pwm_o, kickActive_o, periodStrobe_o
    );
endinterface

// File: rtl/fan_pwm_multi_ctrl.sv
// Multi-channel fan PWM: one shared period counter, per-channel kick/ramp FSM.
// All settings are taken at the period boundary so output edges stay glitch-free.
module fan_pwm_multi_ctrl #(
    parameter int unsigned COUNTER_BITWIDTH = 8,
    parameter int unsigned NUM_CH           = 2,
    parameter int unsigned KICK_PERIODS     = 4,
    parameter int unsigned RAMP_STEP        = 4
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    fan_pwm_multi_ctrl_if.slave bus
);
    localparam int unsigned CB = COUNTER_BITWIDTH;
    localparam int unsigned CW = CB + 1;
    localparam int unsigned KW = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
    localparam logic [CW-1:0] STEP      = CW'(RAMP_STEP);
    localparam logic [KW-1:0] KICK_INIT = KW'(KICK_PERIODS - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_KICK = 2'd1,
        ST_RUN  = 2'd2
    } ch_state_e;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     period_q, period_d;
    logic              strobe_q, strobe_d;
    logic              boundary_c;

    ch_state_e         state_q [NUM_CH];
    ch_state_e         state_d [NUM_CH];
    logic [CW-1:0]     cmp_q   [NUM_CH];
    logic [CW-1:0]     cmp_d   [NUM_CH];
    logic [KW-1:0]     kick_q  [NUM_CH];
    logic [KW-1:0]     kick_d  [NUM_CH];
    logic [CW-1:0]     tgt_c   [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic [NUM_CH-1:0] kact_q, kact_d;

    // Shared period counter; period length is re-shadowed at every boundary.
    always_comb begin
        boundary_c = bus.clk_en_i && (cnt_q == period_q);
        cnt_d      = cnt_q;
        period_d   = period_q;
        strobe_d   = boundary_c;
        if (boundary_c) begin
            cnt_d    = '0;
            period_d = bus.period_i;
        end else if (bus.clk_en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Per-channel target (no overflow at CW bits, clipped to the incoming period) and FSM.
    always_comb begin
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            tgt_c[n] = CW'(bus.duty_i[n*CB +: CB]) + CW'(bus.minDuty_i);
            if (tgt_c[n] > bus.period_i) begin
                tgt_c[n] = bus.period_i;
            end

            state_d[n] = state_q[n];
            cmp_d[n]   = cmp_q[n];
            kick_d[n]  = kick_q[n];
            pwm_d[n]   = pwm_q[n];
            kact_d[n]  = kact_q[n];

            if (bus.clk_en_i) begin
                pwm_d[n]  = (state_q[n] != ST_OFF) &&
                            ((state_q[n] == ST_KICK) || (cnt_q < cmp_q[n]) || (cnt_q == period_q));
                kact_d[n] = (state_q[n] == ST_KICK);
            end

            if (boundary_c) begin
                unique case (state_q[n])
                    ST_OFF: begin
                        cmp_d[n] = '0;
                        if (bus.enable_i[n] && bus.kickEn_i && (tgt_c[n] != '0)) begin
                            state_d[n] = ST_KICK;
                            kick_d[n]  = KICK_INIT;
                        end else if (bus.enable_i[n]) begin
                            state_d[n] = ST_RUN;
                            cmp_d[n]   = (tgt_c[n] < STEP) ? tgt_c[n] : STEP;
                        end
                    end
                    ST_KICK: begin
                        if (!bus.enable_i[n]) begin
                            state_d[n] = ST_OFF;
                            cmp_d[n]   = '0;
                        end else if (kick_q[n] == '0) begin
                            state_d[n] = ST_RUN;
                            cmp_d[n]   = tgt_c[n];
                        end else begin
                            kick_d[n] = kick_q[n] - KW'(1);
                        end
                    end
                    ST_RUN: begin
                        if (!bus.enable_i[n]) begin
                            state_d[n] = ST_OFF;
                            cmp_d[n]   = '0;
                        end else if (tgt_c[n] > cmp_q[n]) begin
                            cmp_d[n] = ((tgt_c[n] - cmp_q[n]) > STEP) ? (cmp_q[n] + STEP) : tgt_c[n];
                        end else if (tgt_c[n] < cmp_q[n]) begin
                            cmp_d[n] = ((cmp_q[n] - tgt_c[n]) > STEP) ? (cmp_q[n] - STEP) : tgt_c[n];
                        end
                    end
                    default: begin
                        state_d[n] = ST_OFF;
                        cmp_d[n]   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q    <= '0;
            period_q <= '0;
            strobe_q <= 1'b0;
            pwm_q    <= '0;
            kact_q   <= '0;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                state_q[n] <= ST_OFF;
                cmp_q[n]   <= '0;
                kick_q[n]  <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            strobe_q <= strobe_d;
            pwm_q    <= pwm_d;
            kact_q   <= kact_d;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                state_q[n] <= state_d[n];
                cmp_q[n]   <= cmp_d[n];
                kick_q[n]  <= kick_d[n];
            end
        end
    end

    assign bus.pwm_o          = pwm_q;
    assign bus.kickActive_o   = kact_q;
    assign bus.periodStrobe_o = strobe_q;

endmodule
